// File: rtl/seq_gen_pkg.sv
// Shared types and reset defaults for the serial sequence generator controller.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'b01011010;
  localparam int         DEFAULT_LEN     = 7;
  localparam int         DEFAULT_REPEAT  = 1;

endpackage

// File: rtl/seq_pass_counter.sv
// Bit-index and pass counters for one pattern playback; idx names the bit shown this cycle.
module seq_pass_counter
  import seq_gen_pkg::*;
#(
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [CNT_W-1:0] repeat_i,
  output logic [LEN_W-1:0] idx_o,
  output logic             last_bit_o,
  output logic             last_pass_o
);

  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;

  assign idx_o       = idx_q;
  assign last_bit_o  = (idx_q == '0);
  // repeat == 0 means endless, so no pass is ever the last one.
  assign last_pass_o = (repeat_i != '0) && (pass_q == repeat_i - 1'b1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    idx_d  = idx_q;
    pass_d = pass_q;
    if (load_i) begin
      idx_d  = len_i;
      pass_d = '0;
    end else if (advance_i) begin
      if (!last_bit_o) begin
        idx_d = idx_q - 1'b1;
      end else if (!last_pass_o) begin
        idx_d = len_i;
        if (repeat_i != '0) pass_d = pass_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pass_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pass_q <= pass_d;
    end
  end

endmodule

// File: rtl/seq_pattern_ctrl.sv
// Programmable pattern player: holds config, runs the IDLE/RUN/DONE FSM and
// drives registered serial outputs MSB-first for the configured number of passes.
module seq_pattern_ctrl
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_W)-1:0] cfg_len,
  input  logic [CNT_W-1:0]         cfg_repeat,
  input  logic                     start,
  input  logic                     stop,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int               LEN_W   = $clog2(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] repeat_q;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, done_q;

  logic             cfg_take;
  logic [LEN_W-1:0] cfg_len_clamped;
  logic [PAT_W-1:0] pattern_eff;
  logic [LEN_W-1:0] len_eff;
  logic             load, advance;
  logic [LEN_W-1:0] idx, idx_dec;
  logic             last_bit, last_pass;

  // A write in the start cycle must feed that run, so the counter and first
  // bit see the incoming config rather than the registers.
  assign cfg_take        = (state_q == IDLE) && cfg_we;
  assign cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign pattern_eff     = cfg_take ? cfg_pattern : pattern_q;
  assign len_eff         = cfg_take ? cfg_len_clamped : len_q;
  assign idx_dec         = idx - 1'b1;

  seq_pass_counter #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_pass_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .advance_i   (advance),
    .len_i       (len_eff),
    .repeat_i    (repeat_q),
    .idx_o       (idx),
    .last_bit_o  (last_bit),
    .last_pass_o (last_pass)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load    = 1'b1;
          dout_d  = pattern_eff[len_eff];
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          advance = 1'b1;
          if (!last_bit) begin
            dout_d  = pattern_q[idx_dec];
            valid_d = 1'b1;
          end else if (!last_pass) begin
            dout_d  = pattern_q[len_q];
            valid_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= PAT_W'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(DEFAULT_LEN);
      repeat_q  <= CNT_W'(DEFAULT_REPEAT);
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_take) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len_clamped;
        repeat_q  <= cfg_repeat;
      end
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Directed bench for seq_pattern_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_seq_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [2:0] cfg_len = '0;
  logic [7:0] cfg_repeat = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dout, dout_valid, busy, done;

  int errors = 0;
  int checks = 0;

  seq_pattern_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_repeat  (cfg_repeat),
    .start       (start),
    .stop        (stop),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [2:0] l, input logic [7:0] r);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_repeat  = r;
    cfg_we      = 1'b1;
    @(negedge clk);
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks n bits MSB-first from bits, then the done pulse and return to idle.
  // poke_kind 1 writes 0xFF config, 2 re-asserts start, in bit cycle poke_at.
  task automatic expect_run(input string tag, input logic [31:0] bits, input int n,
                            input int poke_at, input int poke_kind);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s valid[%0d]", tag, i), {31'd0, dout_valid}, 32'd1);
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s dout[%0d]", tag, i), {31'd0, dout}, {31'd0, bits[n-1-i]});
      if (i == poke_at && poke_kind == 1) begin
        cfg_pattern = 8'hFF;
        cfg_len     = 3'd3;
        cfg_repeat  = 8'd3;
        cfg_we      = 1'b1;
      end
      if (i == poke_at && poke_kind == 2) start = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " done valid"}, {31'd0, dout_valid}, 32'd0);
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done dout"}, {31'd0, dout}, 32'd0);
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle valid"}, {31'd0, dout_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat_a5;
    pat_a5 = 8'hA5;

    repeat (2) @(negedge clk);
    check("rst dout", {31'd0, dout}, 32'd0);
    check("rst valid", {31'd0, dout_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default config after reset.
    pulse_start();
    expect_run("default", 32'b01011010, 8, -1, 0);

    // Two passes of a 4-bit pattern with no gap.
    write_cfg(8'h09, 3'd3, 8'd2);
    pulse_start();
    expect_run("rep2", 32'b10011001, 8, -1, 0);

    // Endless run stopped during the 20th bit.
    write_cfg(8'hA5, 3'd7, 8'd0);
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("inf valid[%0d]", i), {31'd0, dout_valid}, 32'd1);
      check($sformatf("inf dout[%0d]", i), {31'd0, dout}, {31'd0, pat_a5[7-(i%8)]});
      check($sformatf("inf done[%0d]", i), {31'd0, done}, 32'd0);
      if (i == 19) stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stop valid[%0d]", i), {31'd0, dout_valid}, 32'd0);
      check($sformatf("stop busy[%0d]", i), {31'd0, busy}, 32'd0);
      check($sformatf("stop done[%0d]", i), {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Config write during a run is discarded.
    write_cfg(8'h5A, 3'd7, 8'd1);
    pulse_start();
    expect_run("cfg_in_run", 32'b01011010, 8, 2, 1);
    pulse_start();
    expect_run("cfg_kept", 32'b01011010, 8, -1, 0);

    // Start and stop together in idle: no run.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss valid", {31'd0, dout_valid}, 32'd0);
    check("ss busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("ss valid2", {31'd0, dout_valid}, 32'd0);

    // Start during a run does not restart it.
    pulse_start();
    expect_run("restart", 32'b01011010, 8, 3, 2);
    check("restart none", {31'd0, busy}, 32'd0);

    // Reset mid-run restores outputs and default config.
    write_cfg(8'h03, 3'd7, 8'd1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pre_rst dout[%0d]", i), {31'd0, dout}, 32'd0);
      check($sformatf("pre_rst valid[%0d]", i), {31'd0, dout_valid}, 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst dout", {31'd0, dout}, 32'd0);
    check("mid_rst valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst busy", {31'd0, busy}, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    expect_run("post_rst", 32'b01011010, 8, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_ctrl.md
# seq_pattern_ctrl

Programmable controller for the serial sequence-signal generator. It holds a configurable bit pattern, length and repeat count, and on a start pulse plays the pattern MSB-first on a registered serial output for the configured number of passes. It reports busy and done, and accepts an abort. It sits between the lab's control logic (switches/buttons or a bus register) and any block consuming the serial sequence.

## Interface
Parameters:
- PAT_W, default 8: maximum pattern width in bits (2..32).
- CNT_W, default 8: repeat-counter width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous, active-low reset.
- cfg_we, in, 1: config write strobe; honoured only in IDLE.
- cfg_pattern, in, PAT_W: pattern bits; bit cfg_len is played first.
- cfg_len, in, $clog2(PAT_W): pattern length minus 1.
- cfg_repeat, in, CNT_W: number of passes; 0 = run until stop.
- start, in, 1: single-cycle start request.
- stop, in, 1: single-cycle abort request.
- dout, out, 1: serial sequence bit, registered.
- dout_valid, out, 1: dout carries a pattern bit.
- busy, out, 1: high in RUN.
- done, out, 1: one-cycle pulse after the final bit of the final pass.

## Operation
Reset values:
- Config registers: pattern = 8'b01011010 zero-extended to PAT_W, len = 7, repeat = 1.
- State = IDLE.
- Outputs: dout = 0, dout_valid = 0, busy = 0, done = 0.

States:
- IDLE
  - cfg_we latches cfg_pattern, cfg_len and cfg_repeat.
  - start && !stop: go to RUN, set bit index = len, pass count = 0.
  - stop wins over start in the same cycle.
  - If cfg_we and start arrive in the same cycle, the new config is used for that run.
- RUN
  - Each cycle drive dout = pattern[idx] with dout_valid = 1.
  - If idx > 0: idx decrements.
  - If idx == 0 and (repeat == 0 or pass count < repeat-1): reload idx = len and increment pass count.
  - If idx == 0 on the final pass: go to DONE.
  - stop sampled high: go to IDLE on the next edge with no done pulse. The bit shown in the stop cycle is the last valid bit.
  - start and cfg_we are ignored.
- DONE
  - Lasts one cycle: done = 1, dout_valid = 0, dout = 0, busy = 0.
  - Always returns to IDLE. start is ignored in this cycle.

Width and counting rules:
- Pass counter is CNT_W bits.
- With repeat = 0 the counter is not incremented, so it never wraps and the run never ends by itself.
- cfg_len > PAT_W-1 (possible when PAT_W is not a power of 2) is clamped to PAT_W-1 at latch time.
- Reset asserted mid-run immediately forces all reset values, including the default config.

## Timing
- start sampled at edge k: first bit valid in cycle k+1 (1-cycle latency).
- A finite run lasts (len+1)*repeat consecutive valid cycles with no gaps between passes. done is asserted in the cycle immediately after the last valid bit.
- stop sampled at edge m: dout_valid = 0 and busy = 0 from cycle m+1.
- Earliest restart: start sampled in the cycle after DONE, i.e. the first IDLE cycle.
- dout, dout_valid, busy and done are all flop outputs with no combinational paths from inputs.

## Structure
- Package seq_gen_pkg:
  - state enum {IDLE, RUN, DONE};
  - DEFAULT_PATTERN = 8'b01011010, DEFAULT_LEN = 7, DEFAULT_REPEAT = 1.
- One natural sub-module, seq_pass_counter:
  - holds the bit-index and pass counters;
  - inputs: load, advance, len, repeat;
  - outputs: idx, last_bit, last_pass.
- The top module keeps the config registers, the FSM and the output flops.

## Test plan
- Reset, then start with the default config: dout = 0,1,0,1,1,0,1,0 over 8 valid cycles, then done for one cycle, then IDLE.
- cfg_we with pattern 4'b1001, len = 3, repeat = 2, then start: dout = 1,0,0,1,1,0,0,1 with no gap, then a done pulse.
- Pattern 0xA5, repeat = 0, start, stop after 20 valid bits: bits repeat 1,0,1,0,0,1,0,1,…; dout_valid drops the cycle after stop; done never pulses.
- cfg_we with pattern 0xFF during RUN of the default config: output still equals the default pattern. After done, a new start plays the config still held (the in-run write was discarded).
- start and stop in the same IDLE cycle: stays IDLE, dout_valid stays 0. start during RUN: no restart, sequence unchanged.
- Assert rst_n low at bit 3 of a run: all outputs 0 immediately, config back to defaults. A later start plays 01011010.
